clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider with NUM_CH independent outputs derived from clk_in.
- Each channel has a runtime-loadable integer divisor and 50% duty for both even and odd ratios.
- Per-channel enable stops and starts the output without glitches; divisor changes take effect only at a period boundary.
- Sits at the top of the design and supplies the async-FIFO write/read clocks (channel 0 = write, channel 1 = read) plus any further slow clocks.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- CNT_W, 8, divisor/counter width; legal divisor range 2..2^CNT_W-1.
- DEF_DIV, {8'd6, 8'd4}, packed NUM_CH*CNT_W reset divisors; channel 0 in the LSBs (ch0 = /4, ch1 = /6).
- DEF_EN, 2'b11, per-channel enable state that applies until the en input first differs (informational; en input governs).

Ports:
- clk_in  input  1  source clock.
- reset  input  1  reset, asynchronous, active-high.
- en  input  NUM_CH  per-channel run enable.
- div_in  input  NUM_CH*CNT_W  new divisor per channel, packed, ch0 in LSBs.
- div_load  input  NUM_CH  one-cycle strobe; captures the matching div_in slice.
- clk_out  output  NUM_CH  divided clocks.
- tick  output  NUM_CH  one-clk_in-cycle pulse, coincident with each rising edge of clk_out.
- div_active  output  NUM_CH*CNT_W  divisor currently in use per channel.
- load_pending  output  NUM_CH  high while a captured divisor waits for the period boundary.

Behaviour:
- Reset values: clk_out=0, tick=0, load_pending=0, div_active=DEF_DIV, counters=0, running=0. Reset is async on both the posedge and the negedge flops.
- Per channel, state is running (0/1), cnt[CNT_W-1:0], p (posedge phase flop), n (negedge copy of p), div_act, div_pend, pend.
- Start: running=0 and en=1 at posedge, then next state is running=1, cnt=0, p=1, tick=1. clk_out rises 1 clk_in cycle after en is sampled high.
- Run: cnt counts 0..div_act-1 and wraps to 0. Define H = (div_act+1)>>1.
  - p = 1 when next cnt < H, else 0.
  - tick = 1 in the cycle where cnt==0.
- Output for even div_act: clk_out = p, giving div_act/2 cycles high.
- Output for odd div_act: n samples p on negedge clk_in, and clk_out = p & n. This gives high time (div_act/2) cycles, i.e. exactly 50% in half-cycle units.
- Divisor clamp: a loaded value < 2 is clamped to 2. No error flag.
- Load while running: div_load=1 captures div_in into div_pend and sets pend=1. The new value is applied on the wrap cycle (cnt==div_act-1 -> 0), so the new period starts with the new divisor; then pend clears.
- Load while stopped: div_act is updated on the next cycle and pend is never set.
- Back-to-back loads before the boundary: the last one wins.
- Load coincident with the wrap cycle: the old pend value is applied now and the new value becomes pending.
- Stop: en=0 while running finishes the current period (through cnt==div_act-1), then running=0 and clk_out holds low. No runt pulses.
- en re-asserted before the period ends: the channel keeps running with no restart.
- Pending load at stop: it is applied at the final wrap.
- Reset mid-period forces clk_out low immediately (async). A runt high pulse is accepted only on reset.
- Channels are fully independent; simultaneous events on different channels never interact.

Decomposition:
- clk_div_pkg holds:
  - localparam MIN_DIV = 2;
  - function clamp_div (applies MIN_DIV);
  - function half_div (computes H).
- One sub-module, clk_div_channel (parameter CNT_W, DEF_DIV scalar), holds all per-channel logic. It is instantiated NUM_CH times in a generate loop.
- The top level only slices the packed buses.

Test Plan:
- Reset release with en=2'b11 and defaults -> ch0 period 4 cycles (2 high/2 low), ch1 period 6 cycles (3/3). tick on each rising edge; first rise 1 cycle after reset deassert.
- Load div_in ch0=5 mid-period -> load_pending[0]=1 until wrap. The next period is 5 cycles with high time 2.5 cycles (measure on both clk_in edges); div_active[7:0] reads 5 after the boundary.
- Load values 0 and 1 -> div_active=2; clk_out toggles every cycle (period 2).
- en[1] deasserted at cnt=1 of a /6 period -> the current period completes (low phase ends at cnt=5), then clk_out[1] stays 0. Re-assert -> rise 1 cycle later with tick.
- Two loads (7 then 9) within one ch0 period, plus a third load on the wrap cycle itself -> 9 applied at the first boundary, third value applied at the next boundary.
- Assert reset while clk_out=1 -> all outputs 0 immediately. div_active returns to 4/6, load_pending clears.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // Number of counter states with the phase flop high; rounds up for odd divisors.
    function automatic int unsigned half_div(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider; ch0 occupies the LSBs of packed buses.
interface clk_div_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*CNT_W-1:0] div_active;
    logic [NUM_CH-1:0]       load_pending;

    modport master (
        output en, div_in, div_load,
        input  clk_out, tick, div_active, load_pending
    );

    modport slave (
        input  en, div_in, div_load,
        output clk_out, tick, div_active, load_pending
    );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, posedge phase flop and a negedge copy for odd-ratio 50% duty.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] DEF_DIV = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             load_pending
);

    logic             running, p, n, pend, wrap;
    logic [CNT_W-1:0] cnt, cnt_nxt, div_act, div_pend, div_new;

    assign div_new = CNT_W'(clamp_div(32'(div_in)));
    assign wrap    = running && (cnt == div_act - 1'b1);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            running  <= 1'b0;
            cnt      <= '0;
            p        <= 1'b0;
            div_act  <= DEF_DIV;
            div_pend <= DEF_DIV;
            pend     <= 1'b0;
        end else if (!running) begin
            // Idle: loads apply directly, a start begins a fresh period at cnt 0.
            cnt     <= '0;
            running <= en;
            p       <= en;
            pend    <= 1'b0;
            if (div_load)  div_act <= div_new;
            else if (pend) div_act <= div_pend;
        end else begin
            cnt <= cnt_nxt;
            if (wrap) begin
                running <= en;
                p       <= en;
                if (pend) div_act <= div_pend;
            end else begin
                p <= (32'(cnt_nxt) < half_div(32'(div_act)));
            end
            // A load on the wrap edge stays pending for the following boundary.
            if (div_load) begin
                div_pend <= div_new;
                pend     <= 1'b1;
            end else if (wrap) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) n <= 1'b0;
        else       n <= p;
    end

    assign clk_out      = div_act[0] ? (p & n) : p;
    assign tick         = running && (cnt == '0);
    assign div_active   = div_act;
    assign load_pending = pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; slices the packed buses onto per-channel dividers.
module clk_div_multi #(
    parameter int                      NUM_CH  = 2,
    parameter int                      CNT_W   = 8,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {8'd6, 8'd4},
    parameter logic [NUM_CH-1:0]       DEF_EN  = 2'b11
) (
    input logic             clk_in,
    input logic             reset,
    clk_div_multi_if.slave  bus
);

    logic [NUM_CH-1:0]       clk_out_w, tick_w, pend_w;
    logic [NUM_CH*CNT_W-1:0] dact_w;

    // DEF_EN is informational only; the en input always governs.
    if ($bits(DEF_EN) != NUM_CH) begin : g_bad_def_en
        $error("DEF_EN width must equal NUM_CH");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_in       (clk_in),
            .reset        (reset),
            .en           (bus.en[i]),
            .div_in       (bus.div_in[i*CNT_W +: CNT_W]),
            .div_load     (bus.div_load[i]),
            .clk_out      (clk_out_w[i]),
            .tick         (tick_w[i]),
            .div_active   (dact_w[i*CNT_W +: CNT_W]),
            .load_pending (pend_w[i])
        );
    end

    assign bus.clk_out      = clk_out_w;
    assign bus.tick         = tick_w;
    assign bus.div_active   = dact_w;
    assign bus.load_pending = pend_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: measured periods/high time against a queue of expected results.
module tb_clk_div_multi;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    clk_div_multi_if #(.NUM_CH(2), .CNT_W(8)) bus();

    clk_div_multi #(
        .NUM_CH  (2),
        .CNT_W   (8),
        .DEF_DIV (16'h0604),
        .DEF_EN  (2'b11)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus.slave)
    );

    typedef struct {int ch; int per; int hi; int div;} exp_t;
    typedef struct {int ch; int load; int exp_div;} vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int dact(input int ch);
        return int'(bus.div_active[ch*8 +: 8]);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_tick(input int ch, output bit ok);
        int g = 0;
        while (!bus.tick[ch] && g < 1000) begin
            step();
            g++;
        end
        ok = bus.tick[ch];
    endtask

    // From a tick sample, count cycles to the next tick and high half-cycles in between.
    task automatic measure(input int ch, output int per, output int hi, output int d);
        bit ok;
        per = -1; hi = -1; d = -1;
        wait_tick(ch, ok);
        if (ok) begin
            per = 0; hi = 0; d = dact(ch);
            do begin
                hi += int'(bus.clk_out[ch]);
                @(negedge clk_in);
                #1;
                hi += int'(bus.clk_out[ch]);
                step();
                per++;
            end while (!bus.tick[ch] && per < 1000);
        end
    endtask

    function automatic void push(input int ch, input int div);
        exp_t e;
        e.ch = ch; e.per = div; e.hi = div; e.div = div;
        exp_q.push_back(e);
    endfunction

    task automatic check_next(input string name);
        exp_t e;
        int per, hi, d;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        measure(e.ch, per, hi, d);
        chk({name, "_period"}, per, e.per);
        chk({name, "_high_halves"}, hi, e.hi);
        chk({name, "_div_active"}, d, e.div);
    endtask

    task automatic load(input int ch, input int val);
        bus.div_in[ch*8 +: 8] = 8'(val);
        bus.div_load[ch] = 1'b1;
        step();
        bus.div_load[ch] = 1'b0;
    endtask

    initial begin
        bit ok;
        int hi1, t1, g;

        vecs = '{'{0, 5, 5}, '{0, 0, 2}, '{1, 3, 3}, '{0, 1, 2}, '{1, 1, 2},
                 '{0, 255, 255}, '{1, 8, 8}, '{0, 7, 7}, '{0, 4, 4}};

        bus.en = 2'b00; bus.div_in = '0; bus.div_load = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_clk_out", int'(bus.clk_out), 0);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_pending", int'(bus.load_pending), 0);
        chk("rst_div_active", int'(bus.div_active), 16'h0604);

        // Release with both channels enabled; first rise one cycle later.
        @(negedge clk_in);
        reset = 1'b0;
        bus.en = 2'b11;
        step();
        chk("start_tick", int'(bus.tick), 3);
        chk("start_clk_out", int'(bus.clk_out), 3);
        push(0, 4); check_next("def_ch0");
        push(1, 6); check_next("def_ch1");

        // Stop ch1 at cnt=1: period completes, then held low.
        step();
        bus.en[1] = 1'b0;
        hi1 = 0; t1 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi1 += int'(bus.clk_out[1]);
            t1  += int'(bus.tick[1]);
        end
        chk("stop_high_cycles", hi1, 1);
        chk("stop_ticks", t1, 0);
        chk("stop_clk_out", int'(bus.clk_out[1]), 0);
        bus.en[1] = 1'b1;
        step();
        chk("restart_tick", int'(bus.tick[1]), 1);
        chk("restart_clk_out", int'(bus.clk_out[1]), 1);

        // Brief en drop inside a period must not restart the count.
        step();
        bus.en[1] = 1'b0;
        step();
        bus.en[1] = 1'b1;
        g = 0;
        do begin step(); g++; end while (!bus.tick[1] && g < 20);
        chk("blip_gap", g, 4);
        push(1, 6); check_next("blip_ch1");

        for (int i = 0; i < 9; i++) begin
            wait_tick(vecs[i].ch, ok);
            load(vecs[i].ch, vecs[i].load);
            chk($sformatf("v%0d_pending", i), int'(bus.load_pending[vecs[i].ch]), 1);
            push(vecs[i].ch, vecs[i].exp_div);
            check_next($sformatf("v%0d", i));
        end

        // ch0 is /4: loads 7, 9 mid-period, then 3 on the wrap edge.
        wait_tick(0, ok);
        load(0, 7);
        load(0, 9);
        step();
        load(0, 3);
        chk("b2b_active", dact(0), 9);
        chk("b2b_pending", int'(bus.load_pending[0]), 1);
        push(0, 9); push(0, 3);
        check_next("b2b_first");
        chk("b2b_pend_clear", int'(bus.load_pending[0]), 0);
        check_next("b2b_third");

        // Async reset while ch0 is high and ch1 has a pending load.
        wait_tick(1, ok);
        load(1, 5);
        chk("rstseq_pending", int'(bus.load_pending[1]), 1);
        g = 0;
        while (!bus.clk_out[0] && g < 20) begin step(); g++; end
        chk("rstseq_found_high", int'(bus.clk_out[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst2_clk_out", int'(bus.clk_out), 0);
        chk("rst2_tick", int'(bus.tick), 0);
        chk("rst2_pending", int'(bus.load_pending), 0);
        chk("rst2_div_active", int'(bus.div_active), 16'h0604);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
